kfps2kb_fifo_translator: RTL
============================

Name: kfps2kb_fifo_translator

Overview:
Parametrised successor to the single-byte direct PS/2 keyboard controller. Consumes the byte stream from the KFPS2KB shift register and decodes set-2 prefixes (E0, E1, F0) with a state machine. Translates codes to set-1 and queues them in a configurable FIFO, so the XT-side keyboard interface never loses bytes when scancodes arrive faster than the CPU reads them. Keeps the pause and OSD hotkey handling, now parametrised.

Parameters:
FIFO_DEPTH, 8, number of queued set-1 bytes; power of two, ≥2
PASS_E0, 1, 1 = forward E0 prefixes to the FIFO; 0 = strip them
HOTKEY_PAUSE, 8'h78, set-2 code whose break toggles pause_core (F11)
HOTKEY_MASK, 8'h07, set-2 code silently dropped, both make and break (F12, reserved for the OSD)

Ports:
clock  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  byte from the shift register
rx_valid  in  1  one-cycle strobe; rx_data is valid
rx_error  in  1  one-cycle strobe; parity, framing or timeout error
clear_keycode  in  1  pops the FIFO head
reset_keyboard  in  1  flushes the FIFO and queues 8'hAA
irq  out  1  FIFO not empty
keycode  out  8  FIFO head; 8'h00 when empty
pause_core  out  1  core paused
overflow  out  1  sticky overrun flag
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset: irq=0, keycode=00, pause_core=0, overflow=0, fifo_count=0, decoder state IDLE.
- Decoder states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Each state consumes one byte per rx_valid.
- FA (ACK): discarded; state unchanged.
- E0: state→GOT_E0; push E0 if PASS_E0 and not paused.
- E1: pushed as E1 unless paused; state unchanged.
- F0: IDLE→GOT_F0; GOT_E0→GOT_E0F0.
- Any other code c: out = T(c) | (break ? 8'h80 : 0), where T is the standard KFPS2KB set-2→set-1 table (1C→1E, 76→01, 14→1D, 77→45, 83→41, 12→2A) and break = state ∈ {GOT_F0, GOT_E0F0}. Push out; state→IDLE.
- Hotkeys: matched only from IDLE or GOT_F0, i.e. not extended.
  - c==HOTKEY_MASK: nothing pushed.
  - c==HOTKEY_PAUSE: nothing pushed; on break, pause_core toggles.
- While pause_core=1, every push is suppressed except the reset_keyboard AA. Decoder state still advances.
- Pause key set-2 sequence E1 14 77 E1 F0 14 F0 77 yields E1 1D 45 E1 9D C5.
- rx_error: state→IDLE; push FF.
- FIFO: circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits, wrapping naturally.
  - keycode = mem[rd] when count>0, else 00. irq = (count!=0).
  - Latency: rx_valid in cycle N on an empty FIFO → irq=1 and keycode valid in N+1.
- Pop (clear_keycode): count>0 → rd+1. Pop on empty is ignored.
- Push with count<DEPTH: write at wr; wr+1.
- Push with count==DEPTH and no same-cycle pop: overwrite the newest entry (wr−1) with FF; overflow=1; count unchanged.
- Push and pop in the same cycle: both occur; count unchanged; no overflow, even if full.
- reset_keyboard (priority over all else except reset):
  - pointers and count cleared; mem[0]=AA; count=1; overflow=0; state IDLE.
  - pause_core unchanged; same-cycle rx and pop ignored.
- rx_valid and rx_error in the same cycle: error wins, byte dropped.
- overflow is cleared only by reset or reset_keyboard.
- At most one push per cycle.

Test Plan:
- Set-2 1C, F0 1C with no pops → fifo_count=2, keycode=1E, irq=1. After pop → keycode 9E. After second pop → irq=0, keycode=00.
- Extended E0 75, E0 F0 75 with PASS_E0=1 → queue E0 48 E0 C8. With PASS_E0=0 → 48 C8.
- FIFO_DEPTH=4; push 01,02,03,04, then 05 with no pop → queue 01 02 03 FF, overflow=1. Push and pop in the same full cycle → no overflow change, count=4.
- 78, then F0 78 → nothing queued, pause_core=1. Then 1C → dropped. Then F0 78 → pause_core=0. 07 / F0 07 → never queued.
- rx_error with 2 queued entries → third entry FF, decoder back to IDLE (a following 1C yields 1E, not 9E, even after a pending F0).
- reset_keyboard with 3 queued and overflow=1 → next cycle fifo_count=1, keycode=AA, overflow=0. Synchronous reset mid-sequence (after E0 F0) → all outputs at reset values; next 1C → 1E.

Source files
------------

// File: rtl/kfps2kb_fifo_translator_if.sv
// kfps2kb_fifo_translator_if: byte-stream, FIFO-control and status bundle of the set-2 to set-1 translator
interface kfps2kb_fifo_translator_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_error;
  logic clear_keycode;
  logic reset_keyboard;
  logic irq;
  logic [7:0] keycode;
  logic pause_core;
  logic overflow;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  modport master (
    output rx_data, rx_valid, rx_error, clear_keycode, reset_keyboard,
    input irq, keycode, pause_core, overflow, fifo_count
  );
  modport slave (
    input rx_data, rx_valid, rx_error, clear_keycode, reset_keyboard,
    output irq, keycode, pause_core, overflow, fifo_count
  );
endinterface

// File: rtl/kfps2kb_fifo_translator.sv
// kfps2kb_fifo_translator: PS/2 set-2 prefix decoder, set-1 translator and keycode FIFO with pause/OSD hotkeys
module kfps2kb_fifo_translator #(
  parameter int FIFO_DEPTH = 8,
  parameter bit PASS_E0 = 1'b1,
  parameter logic [7:0] HOTKEY_PAUSE = 8'h78,
  parameter logic [7:0] HOTKEY_MASK = 8'h07
) (
  input logic clock,
  input logic reset,
  kfps2kb_fifo_translator_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, waddr;
  logic [CW-1:0] count_q, count_d;
  logic pause_q, pause_d, ovf_q, ovf_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] rx, push_data, wdata;
  logic push_req, pause_tgl, push, pop, grow, wen, ext, brk, hot;
  function automatic logic [7:0] set1(input logic [7:0] c);
    case (c)
      8'h01: set1 = 8'h43; 8'h03: set1 = 8'h3F; 8'h04: set1 = 8'h3D; 8'h05: set1 = 8'h3B;
      8'h06: set1 = 8'h3C; 8'h07: set1 = 8'h58; 8'h09: set1 = 8'h44; 8'h0A: set1 = 8'h42;
      8'h0B: set1 = 8'h40; 8'h0C: set1 = 8'h3E; 8'h0D: set1 = 8'h0F; 8'h0E: set1 = 8'h29;
      8'h11: set1 = 8'h38; 8'h12: set1 = 8'h2A; 8'h14: set1 = 8'h1D; 8'h15: set1 = 8'h10;
      8'h16: set1 = 8'h02; 8'h1A: set1 = 8'h2C; 8'h1B: set1 = 8'h1F; 8'h1C: set1 = 8'h1E;
      8'h1D: set1 = 8'h11; 8'h1E: set1 = 8'h03; 8'h21: set1 = 8'h2E; 8'h22: set1 = 8'h2D;
      8'h23: set1 = 8'h20; 8'h24: set1 = 8'h12; 8'h25: set1 = 8'h05; 8'h26: set1 = 8'h04;
      8'h29: set1 = 8'h39; 8'h2A: set1 = 8'h2F; 8'h2B: set1 = 8'h21; 8'h2C: set1 = 8'h14;
      8'h2D: set1 = 8'h13; 8'h2E: set1 = 8'h06; 8'h31: set1 = 8'h31; 8'h32: set1 = 8'h30;
      8'h33: set1 = 8'h23; 8'h34: set1 = 8'h22; 8'h35: set1 = 8'h15; 8'h36: set1 = 8'h07;
      8'h3A: set1 = 8'h32; 8'h3B: set1 = 8'h24; 8'h3C: set1 = 8'h16; 8'h3D: set1 = 8'h08;
      8'h3E: set1 = 8'h09; 8'h41: set1 = 8'h33; 8'h42: set1 = 8'h25; 8'h43: set1 = 8'h17;
      8'h44: set1 = 8'h18; 8'h45: set1 = 8'h0B; 8'h46: set1 = 8'h0A; 8'h49: set1 = 8'h34;
      8'h4A: set1 = 8'h35; 8'h4B: set1 = 8'h26; 8'h4C: set1 = 8'h27; 8'h4D: set1 = 8'h19;
      8'h4E: set1 = 8'h0C; 8'h52: set1 = 8'h28; 8'h54: set1 = 8'h1A; 8'h55: set1 = 8'h0D;
      8'h58: set1 = 8'h3A; 8'h59: set1 = 8'h36; 8'h5A: set1 = 8'h1C; 8'h5B: set1 = 8'h1B;
      8'h5D: set1 = 8'h2B; 8'h66: set1 = 8'h0E; 8'h69: set1 = 8'h4F; 8'h6B: set1 = 8'h4B;
      8'h6C: set1 = 8'h47; 8'h70: set1 = 8'h52; 8'h71: set1 = 8'h53; 8'h72: set1 = 8'h50;
      8'h73: set1 = 8'h4C; 8'h74: set1 = 8'h4D; 8'h75: set1 = 8'h48; 8'h76: set1 = 8'h01;
      8'h77: set1 = 8'h45; 8'h78: set1 = 8'h57; 8'h79: set1 = 8'h4E; 8'h7A: set1 = 8'h51;
      8'h7B: set1 = 8'h4A; 8'h7C: set1 = 8'h37; 8'h7D: set1 = 8'h49; 8'h7E: set1 = 8'h46;
      8'h83: set1 = 8'h41;
      default: set1 = 8'h00;
    endcase
  endfunction
  assign rx = bus.rx_data;
  assign ext = state_q == GOT_E0 || state_q == GOT_E0F0;
  assign brk = state_q == GOT_F0 || state_q == GOT_E0F0;
  assign hot = !ext;
  assign pop = bus.clear_keycode && count_q != '0;
  assign push = push_req && !pause_q;
  assign grow = push && (count_q != FULL || pop);
  // decoder state register
  always_ff @(posedge clock) begin
    state_q <= reset ? IDLE : state_d;
  end
  // prefix decoding: E0/F0 build up the extended/break context, any final code returns to IDLE
  always_comb begin
    state_d = bus.reset_keyboard || bus.rx_error ? IDLE :
              !bus.rx_valid || rx == 8'hFA || rx == 8'hE1 ? state_q :
              rx == 8'hE0 ? GOT_E0 :
              rx == 8'hF0 ? (ext ? GOT_E0F0 : GOT_F0) : IDLE;
  end
  // per-byte action: what to queue and whether the pause hotkey fires
  always_comb begin
    push_req = 1'b0;
    pause_tgl = 1'b0;
    push_data = set1(rx) | {brk, 7'b0};
    if (bus.rx_error) begin
      push_req = 1'b1;
      push_data = 8'hFF;
    end else if (bus.rx_valid) begin
      if (rx == 8'hE0) begin
        push_req = PASS_E0;
        push_data = 8'hE0;
      end else if (rx == 8'hE1) begin
        push_req = 1'b1;
        push_data = 8'hE1;
      end else if (rx != 8'hFA && rx != 8'hF0) begin
        pause_tgl = hot && brk && rx == HOTKEY_PAUSE;
        push_req = !(hot && (rx == HOTKEY_PAUSE || rx == HOTKEY_MASK));
      end
    end
  end
  // FIFO bookkeeping; a push into a full FIFO without a pop marks the newest entry as FF
  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    count_d = count_q;
    ovf_d = ovf_q;
    pause_d = pause_q;
    wen = 1'b0;
    waddr = wr_q;
    wdata = push_data;
    if (bus.reset_keyboard) begin
      rd_d = '0;
      wr_d = AW'(1);
      count_d = CW'(1);
      ovf_d = 1'b0;
      wen = 1'b1;
      waddr = '0;
      wdata = 8'hAA;
    end else begin
      pause_d = pause_q ^ pause_tgl;
      rd_d = rd_q + AW'(pop);
      wr_d = wr_q + AW'(grow);
      count_d = count_q + CW'(grow) - CW'(pop);
      wen = push;
      waddr = grow ? wr_q : wr_q - AW'(1);
      wdata = grow ? push_data : 8'hFF;
      ovf_d = ovf_q | (push && !grow);
    end
  end
  // FIFO pointers, occupancy and sticky flags
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      pause_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      pause_q <= pause_d;
      ovf_q <= ovf_d;
    end
  end
  // storage needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clock) begin
    if (wen) mem_q[waddr] <= wdata;
  end
  assign bus.irq = count_q != '0;
  assign bus.keycode = bus.irq ? mem_q[rd_q] : 8'h00;
  assign bus.pause_core = pause_q;
  assign bus.overflow = ovf_q;
  assign bus.fifo_count = count_q;
endmodule
